// File: rtl/bram_seq_pkg.sv
// ---------------------------------------------------------------------------
// bram_seq_pkg
// Shared types for the BRAM request sequencer:
//   seq_state_t        - sequencer FSM states
//   bram_req_t         - queued request {we, addr, wdata}
//   MEM_LAT_MAX/LAT_W  - largest supported BRAM latency and counter width
//   addr_out_of_range  - in-window range check on a byte address
// ---------------------------------------------------------------------------
package bram_seq_pkg;

   localparam int MEM_LAT_MAX = 15;
   localparam int LAT_W       = 4;    // holds 0..MEM_LAT_MAX-1
   localparam int ADDR_W_MAX  = 64;   // request addresses are zero-extended to this

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      ERR   = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic [3:0]            we;
      logic [ADDR_W_MAX-1:0] addr;
      logic [31:0]           wdata;
   } bram_req_t;

   // OR of address bits [hi-1:lo]; any set bit means the word lies past the BRAM.
   function automatic logic addr_out_of_range(input logic [ADDR_W_MAX-1:0] addr,
                                              input int lo, input int hi);
      logic oor;
      oor = 1'b0;
      for (int i = 0; i < ADDR_W_MAX; i++) begin
         if ((i >= lo) && (i < hi)) begin
            oor = oor | addr[i];
         end else begin
            oor = oor;
         end
      end
      return oor;
   endfunction

endpackage

// File: rtl/bram_req_sequencer_fifo.sv
// ---------------------------------------------------------------------------
// req_fifo2
// Two-entry synchronous skid FIFO for queued BRAM requests.
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write side (push ignored when full)
//   pop, rdata      read side; rdata is the head entry (pop ignored when empty)
//   full, empty     occupancy flags decoded from the registered count
//   count           occupancy 0..2
// ---------------------------------------------------------------------------
import bram_seq_pkg::*;

module req_fifo2 #(
   parameter int W = $bits(bram_req_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] mem_r [2];
   logic         wr_ptr_r;
   logic         rd_ptr_r;
   logic [1:0]   count_r;
   logic         push_s;
   logic         pop_s;

   assign push_s = push && (count_r != 2'd2);
   assign pop_s  = pop  && (count_r != 2'd0);

   // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign full  = (count_r == 2'd2);
   assign empty = (count_r == 2'd0);
   assign count = count_r;

endmodule

// File: rtl/bram_req_sequencer.sv
// ---------------------------------------------------------------------------
// bram_req_sequencer
// Turns the decoded Wishbone request stream into single-port BRAM accesses and
// returns exactly one response per accepted request, in order.
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready = FIFO not full)
//   req_we, req_addr, req_wdata   byte strobes (0 = read), byte address, data
//   rsp_valid, rsp_rdata, rsp_err one-cycle response; rdata is 0 for writes/errors
//   bram_en, bram_we, bram_addr,
//   bram_di, bram_do              BRAM macro interface (word addressed)
//   pending                       FIFO occupancy 0..2
// Parameters: MEM_LAT (1..15) BRAM read latency, DEPTH_W log2 word depth,
// ADDR_W request address width (<= 64), WIN_W width of the byte window the
// front-end hands us; bits at and above WIN_W are the region select it has
// already decoded, so only bits [WIN_W-1:DEPTH_W+2] decide the range error.
// ---------------------------------------------------------------------------
import bram_seq_pkg::*;

module bram_req_sequencer #(
   parameter int MEM_LAT = 1,
   parameter int DEPTH_W = 10,
   parameter int ADDR_W  = 32,
   parameter int WIN_W   = 24
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_we,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [31:0]        req_wdata,
   output logic               rsp_valid,
   output logic [31:0]        rsp_rdata,
   output logic               rsp_err,
   output logic               bram_en,
   output logic [3:0]         bram_we,
   output logic [DEPTH_W-1:0] bram_addr,
   output logic [31:0]        bram_di,
   input  logic [31:0]        bram_do,
   output logic [1:0]         pending
);

   bram_req_t    push_req_s;
   bram_req_t    head_s;
   logic         fifo_full_s;
   logic         fifo_empty_s;
   logic [1:0]   fifo_cnt_s;
   logic         pop_s;
   logic         head_oor_s;
   logic         lat_done_s;

   seq_state_t   state_r;
   seq_state_t   state_nxt_s;
   logic [3:0]   cur_we_r;
   logic [LAT_W-1:0] lat_cnt_r;

   logic               rsp_valid_r;
   logic [31:0]        rsp_rdata_q;
   logic               rsp_err_q;
   logic               bram_en_r;
   logic [3:0]         bram_we_r;
   logic [DEPTH_W-1:0] bram_addr_r;
   logic [31:0]        bram_di_r;

   assign push_req_s.we    = req_we;
   assign push_req_s.addr  = ADDR_W_MAX'(req_addr);
   assign push_req_s.wdata = req_wdata;

   req_fifo2 #(.W($bits(bram_req_t))) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (req_valid),
      .wdata (push_req_s),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_cnt_s)
   );

   assign head_oor_s = addr_out_of_range(head_s.addr, DEPTH_W + 2, WIN_W);
   // Capture point: BRAM data is valid MEM_LAT-1 WAIT cycles after ISSUE.
   assign lat_done_s = (lat_cnt_r == LAT_W'(MEM_LAT - 1));

   // Next-state decode; the head is popped on the IDLE->ISSUE/ERR transition.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s = 1'b1;
               if (head_oor_s) begin
                  state_nxt_s = ERR;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: state_nxt_s = WAIT;
         WAIT: begin
            if (lat_done_s) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP:    state_nxt_s = IDLE;
         ERR:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM state, current-request strobes and latency counter.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r   <= IDLE;
         cur_we_r  <= 4'd0;
         lat_cnt_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (pop_s) begin
            cur_we_r <= head_s.we;
         end
         if (state_r == ISSUE) begin
            lat_cnt_r <= '0;
         end else if (state_r == WAIT) begin
            lat_cnt_r <= lat_cnt_r + 1'b1;
         end
      end
   end

   // Registered outputs, loaded from the next state so they line up with it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         bram_en_r   <= 1'b0;
         bram_we_r   <= 4'd0;
         bram_addr_r <= '0;
         bram_di_r   <= 32'd0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         bram_en_r <= (state_nxt_s == ISSUE);
         if (state_nxt_s == ISSUE) begin
            bram_we_r   <= head_s.we;
            bram_addr_r <= head_s.addr[DEPTH_W+1:2];
            bram_di_r   <= head_s.wdata;
         end else begin
            bram_we_r <= 4'd0;
         end
         rsp_valid_r <= (state_nxt_s == RESP) || (state_nxt_s == ERR);
         rsp_err_q   <= (state_nxt_s == ERR);
         // WAIT with lat_done is exactly the WAIT->RESP edge: sample the BRAM here.
         if ((state_r == WAIT) && lat_done_s && (cur_we_r == 4'd0)) begin
            rsp_rdata_q <= bram_do;
         end else begin
            rsp_rdata_q <= 32'd0;
         end
      end
   end

   assign req_ready = !fifo_full_s;
   assign pending   = fifo_cnt_s;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign bram_en   = bram_en_r;
   assign bram_we   = bram_we_r;
   assign bram_addr = bram_addr_r;
   assign bram_di   = bram_di_r;

endmodule

// File: tb/tb_bram_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bram_req_sequencer
// Two instances: MEM_LAT=1 (main traffic) and MEM_LAT=3 (latency check).
// Behavioural BRAM models return garbage except at the true latency point.
// Expected responses are queued at acceptance and checked on rsp_valid.
// ---------------------------------------------------------------------------
module tb_bram_req_sequencer;

   localparam int LAT1 = 1;
   localparam int LAT3 = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_valid3;
   logic [3:0]  req_we;
   logic [31:0] req_addr, req_wdata;

   logic        req_ready, rsp_valid, rsp_err, bram_en;
   logic [31:0] rsp_rdata, bram_di, bram_do;
   logic [3:0]  bram_we;
   logic [9:0]  bram_addr;
   logic [1:0]  pending;

   logic        req_ready3, rsp_valid3, rsp_err3, bram_en3;
   logic [31:0] rsp_rdata3, bram_di3, bram_do3;
   logic [3:0]  bram_we3;
   logic [9:0]  bram_addr3;
   logic [1:0]  pending3;

   always #5 clk = ~clk;

   bram_req_sequencer #(.MEM_LAT(LAT1), .DEPTH_W(10), .ADDR_W(32)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_di(bram_di), .bram_do(bram_do), .pending(pending));

   bram_req_sequencer #(.MEM_LAT(LAT3), .DEPTH_W(10), .ADDR_W(32)) dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
      .bram_en(bram_en3), .bram_we(bram_we3), .bram_addr(bram_addr3),
      .bram_di(bram_di3), .bram_do(bram_do3), .pending(pending3));

   // BRAM models
   logic [31:0] mem1 [1024];
   logic [31:0] mem3 [1024];
   logic [31:0] p3   [3];

   always @(posedge clk) begin
      if (bram_en) begin
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem1[bram_addr][8*b +: 8] <= bram_di[8*b +: 8];
         bram_do <= mem1[bram_addr];
      end else begin
         bram_do <= 32'hBAD0_BAD0;
      end
   end

   always @(posedge clk) begin
      if (bram_en3) begin
         for (int b = 0; b < 4; b++)
            if (bram_we3[b]) mem3[bram_addr3][8*b +: 8] <= bram_di3[8*b +: 8];
         p3[0] <= mem3[bram_addr3];
      end else begin
         p3[0] <= 32'hBAD0_BAD0;
      end
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign bram_do3 = p3[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;   // 0 = latency not checked
   } exp_t;

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t sb[$];
   int   rsp_cyc[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Response monitor: every rsp_valid pops and checks one expected entry.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         rsp_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got response in cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
            if (mon_e.lat > 0) chk("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit chk_lat);
      int   n;
      exp_t e;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: req_ready stayed %b, expected 1", req_ready);
      end else begin
         e.rdata = exp_rdata;
         e.err   = exp_err;
         e.acc   = cyc;
         e.lat   = chk_lat ? (exp_err ? 2 : LAT1 + 3) : 0;
         sb.push_back(e);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   vec_t vt [12];
   vec_t vb [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int n;
      logic [31:0] a3 [2];
      logic [31:0] r3 [2];
      logic        e3 [2];
      int          l3 [2];

      for (int i = 0; i < 1024; i++) begin
         mem1[i] = 32'd0;
         mem3[i] = 32'd0;
      end
      mem3[4] = 32'hDEAD_BEEF;

      vt[0]  = '{4'h0, 32'h3800_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vt[1]  = '{4'h5, 32'h3800_0010, 32'h1122_3344, 32'h0000_0000, 1'b0};
      vt[2]  = '{4'h0, 32'h3800_0012, 32'h0000_0000, 32'hDE22_BE44, 1'b0};
      vt[3]  = '{4'h0, 32'h3800_0020, 32'h0000_0000, 32'h00AA_00AA, 1'b0};
      vt[4]  = '{4'hF, 32'h3800_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      vt[5]  = '{4'h0, 32'h3800_0FFF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      vt[6]  = '{4'h0, 32'h3800_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vt[7]  = '{4'hF, 32'h3800_1010, 32'h0BAD_F00D, 32'h0000_0000, 1'b1};
      vt[8]  = '{4'h0, 32'h3800_0010, 32'h0000_0000, 32'hDE22_BE44, 1'b0};
      vt[9]  = '{4'h0, 32'h3880_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vt[10] = '{4'h8, 32'h3800_0004, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
      vt[11] = '{4'h0, 32'h3800_0006, 32'h0000_0000, 32'hA500_0000, 1'b0};

      vb[0]  = '{4'h0, 32'h3800_0010, 32'h0, 32'hDE22_BE44, 1'b0};
      vb[1]  = '{4'h0, 32'h3800_0020, 32'h0, 32'h00AA_00AA, 1'b0};
      vb[2]  = '{4'h0, 32'h3800_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0};
      vb[3]  = '{4'h0, 32'h3800_0004, 32'h0, 32'hA500_0000, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0;
      req_we = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
      tick();
      tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
      chk("rst_bram_en",   {31'd0, bram_en}, 32'd0);
      chk("rst_bram_we",   {28'd0, bram_we}, 32'd0);
      chk("rst_pending",   {30'd0, pending}, 32'd0);
      rst = 1'b0;
      tick();

      // Full write: BRAM access in cycle 2, response in cycle 4
      send(4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
      chk("wr_pending_c1", {30'd0, pending}, 32'd1);
      tick();
      chk("wr_bram_en", {31'd0, bram_en}, 32'd1);
      chk("wr_bram_we", {28'd0, bram_we}, 32'hF);
      chk("wr_bram_addr", {22'd0, bram_addr}, 32'd4);
      chk("wr_bram_di", bram_di, 32'hDEAD_BEEF);
      chk("wr_pending_c2", {30'd0, pending}, 32'd0);
      drain();

      // Partial write strobes pass through unchanged
      send(4'h5, 32'h3800_0020, 32'h55AA_55AA, 32'h0, 1'b0, 1'b1);
      tick();
      chk("pw_bram_we", {28'd0, bram_we}, 32'h5);
      chk("pw_bram_addr", {22'd0, bram_addr}, 32'd8);
      drain();

      // Table-driven single requests
      for (int i = 0; i < 12; i++) begin
         send(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, 1'b1);
         drain();
      end

      // Out-of-range read: no BRAM enable in cycles 1..3
      send(4'h0, 32'h3800_1000, 32'h0, 32'h0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("err_no_bram_en", {31'd0, bram_en}, 32'd0);
         tick();
      end
      drain();

      // Back-to-back burst: FIFO fills, ready drops, responses spaced MEM_LAT+3
      rsp_cyc.delete();
      for (int k = 0; k < 4; k++) begin
         send(vb[k].we, vb[k].addr, vb[k].wdata, vb[k].rdata, vb[k].err, 1'b0);
         if (k == 2) begin
            chk("burst_pending_full", {30'd0, pending}, 32'd2);
            chk("burst_ready_low", {31'd0, req_ready}, 32'd0);
         end
      end
      drain();
      chk("burst_rsp_count", 32'(rsp_cyc.size()), 32'd4);
      for (int k = 1; k < 4 && k < rsp_cyc.size(); k++)
         chk("burst_spacing", 32'(rsp_cyc[k] - rsp_cyc[k-1]), 32'(LAT1 + 3));

      // Reset while in WAIT with one request queued
      send(4'h0, 32'h3800_0010, 32'h0, 32'hDE22_BE44, 1'b0, 1'b0);
      send(4'h0, 32'h3800_0020, 32'h0, 32'h00AA_00AA, 1'b0, 1'b0);
      tick();
      chk("mid_pending_before", {30'd0, pending}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      chk("mid_pending_after", {30'd0, pending}, 32'd0);
      chk("mid_ready_after", {31'd0, req_ready}, 32'd1);
      chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      for (int k = 0; k < 6; k++) tick();
      send(4'h0, 32'h3800_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      drain();

      // MEM_LAT=3 instance: read latency 6, error latency 2
      a3[0] = 32'h3800_0010; r3[0] = 32'hDEAD_BEEF; e3[0] = 1'b0; l3[0] = LAT3 + 3;
      a3[1] = 32'h3800_1000; r3[1] = 32'h0000_0000; e3[1] = 1'b1; l3[1] = 2;
      for (int k = 0; k < 2; k++) begin
         req_we = 4'h0; req_addr = a3[k]; req_wdata = 32'h0;
         chk("l3_ready", {31'd0, req_ready3}, 32'd1);
         req_valid3 = 1'b1;
         tick();
         req_valid3 = 1'b0;
         c0 = cyc - 1;
         n = 0;
         while (rsp_valid3 !== 1'b1 && n < 40) begin
            tick();
            n++;
         end
         chk("l3_latency", 32'(cyc - c0), 32'(l3[k]));
         chk("l3_rdata", rsp_rdata3, r3[k]);
         chk("l3_err", {31'd0, rsp_err3}, {31'd0, e3[k]});
         tick();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
